// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder types: subsampling modes, component ids, block type and
// the upsampler FSM state encoding.
package jpeg_pkg;

   typedef enum logic [1:0] {SS_444, SS_422, SS_420, SS_RSVD} subsamp_mode_t;

   localparam int CH_Y  = 0;
   localparam int CH_CB = 1;
   localparam int CH_CR = 2;

   localparam int PIX_DW  = 8;
   localparam int PIX_BLK = 8;
   typedef logic [PIX_BLK-1:0][PIX_BLK-1:0][PIX_DW-1:0] pix_block_t;

   typedef enum logic {ST_IDLE, ST_EMIT} ups_state_t;

   // Index of the final output block for a given (already resolved) mode.
   function automatic logic [1:0] last_idx(input subsamp_mode_t m);
      case (m)
         SS_422:  return 2'd1;
         SS_420:  return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/chroma_replicate.sv
// Pixel-replication mapping from a buffered component block to one
// full-resolution output block, selected by mode and sub-block index.
module chroma_replicate
   import jpeg_pkg::*;
#(
   parameter int DW  = 8,
   parameter int BLK = 8
) (
   input  logic [BLK-1:0][BLK-1:0][DW-1:0] i_buf,
   input  logic [1:0]                      i_mode,
   input  logic [1:0]                      i_idx,
   output logic [BLK-1:0][BLK-1:0][DW-1:0] o_block
);

   localparam int H = BLK / 2;

   // idx[0] picks the right half, idx[1] the bottom half of the source block.
   for (genvar gi = 0; gi < BLK; gi++) begin : g_row
      for (genvar gj = 0; gj < BLK; gj++) begin : g_col
         logic [DW-1:0] w_h;
         logic [DW-1:0] w_q;

         assign w_h = i_idx[0] ? i_buf[gi][H + gj/2] : i_buf[gi][gj/2];
         assign w_q = i_idx[1]
                    ? (i_idx[0] ? i_buf[H + gi/2][H + gj/2] : i_buf[H + gi/2][gj/2])
                    : (i_idx[0] ? i_buf[gi/2][H + gj/2]     : i_buf[gi/2][gj/2]);

         assign o_block[gi][gj] = (i_mode == SS_420) ? w_q :
                                  (i_mode == SS_422) ? w_h : i_buf[gi][gj];
      end
   end

endmodule

// File: rtl/chroma_upsampler.sv
// Chroma upsampler: buffers one component block and emits 1, 2 or 4
// replicated full-resolution blocks with valid/ready on both sides.
module chroma_upsampler
   import jpeg_pkg::*;
#(
   parameter int DW   = 8,
   parameter int BLK  = 8,
   parameter int CH_W = 2
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [CH_W-1:0]                 in_ch,
   input  logic [1:0]                      in_mode,
   input  logic [BLK-1:0][BLK-1:0][DW-1:0] in_block,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [CH_W-1:0]                 out_ch,
   output logic [1:0]                      out_idx,
   output logic                            out_last,
   output logic [BLK-1:0][BLK-1:0][DW-1:0] out_block,
   output logic                            mode_err,
   output logic                            dbg_state
);

   // Handshake: a transfer happens on a side only in a cycle where both its
   // valid and ready are high at the rising clock edge; valid never waits on ready.

   ups_state_t                      r_state;
   ups_state_t                      w_next_state;
   logic [BLK-1:0][BLK-1:0][DW-1:0] r_buf;
   logic [CH_W-1:0]                 r_ch;
   logic [1:0]                      r_idx;
   subsamp_mode_t                   r_mode;
   subsamp_mode_t                   w_eff_mode;
   logic                            r_mode_err;
   logic                            w_accept;
   logic                            w_out_fire;
   logic                            w_out_last;

   // Luma and reserved modes collapse to a single passthrough block.
   always_comb begin
      w_eff_mode = subsamp_mode_t'(in_mode);
      if ((in_ch == CH_W'(CH_Y)) || (in_mode == SS_RSVD))
         w_eff_mode = SS_444;
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_out_last   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next_state = ST_EMIT;
         end
         ST_EMIT: begin
            out_valid  = 1'b1;
            w_out_last = (r_idx == last_idx(r_mode));
            in_ready   = out_ready && w_out_last;
            if (out_ready && w_out_last && !in_valid) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_accept   = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_buf      <= '0;
         r_ch       <= '0;
         r_idx      <= 2'd0;
         r_mode     <= SS_444;
         r_mode_err <= 1'b0;
      end else begin
         r_mode_err <= w_accept && (in_mode == SS_RSVD);
         if (w_accept) begin
            r_buf  <= in_block;
            r_ch   <= in_ch;
            r_mode <= w_eff_mode;
            r_idx  <= 2'd0;
         end else if (w_out_fire && !w_out_last) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   chroma_replicate #(.DW(DW), .BLK(BLK)) u_replicate (
      .i_buf   (r_buf),
      .i_mode  (r_mode),
      .i_idx   (r_idx),
      .o_block (out_block)
   );

   assign out_ch    = r_ch;
   assign out_idx   = r_idx;
   assign out_last  = w_out_last;
   assign mode_err  = r_mode_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_chroma_upsampler.sv
// Directed testbench for chroma_upsampler: replication maps, back-to-back
// input, output stalls, mid-emission reset and reserved-mode handling.
module tb_chroma_upsampler;
   import jpeg_pkg::*;

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_ch;
   logic [1:0]       in_mode;
   pix_block_t       in_block;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_ch;
   logic [1:0]       out_idx;
   logic             out_last;
   pix_block_t       out_block;
   logic             mode_err;
   logic             dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   pix_block_t ramp, blk_a, blk_b, snap_blk;
   logic [1:0] snap_idx, snap_ch;
   logic       snap_last, stalled;
   int         hs_cnt;
   logic       ready_pat [0:7];
   logic [7:0] tl_exp [0:3];

   chroma_upsampler #(.DW(8), .BLK(8), .CH_W(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch     (in_ch),
      .in_mode   (in_mode),
      .in_block  (in_block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_block (out_block),
      .mode_err  (mode_err),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // driver / checker tasks
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(input string tag, input pix_block_t obs, input pix_block_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_block(output pix_block_t b);
      for (int w = 0; w < 16; w++) b[w*4 +: 4] = $urandom;
   endtask

   initial begin
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            ramp[r][c] = 8'(r * 8 + c);
      rand_block(blk_a);
      rand_block(blk_b);

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_ch     = 2'd0;
      in_mode   = 2'd0;
      in_block  = '0;
      out_ready = 1'b0;
      step();

      // reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_idx",   32'(out_idx),   32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_ch",    32'(out_ch),    32'd0);
      chk("rst_mode_err",  32'(mode_err),  32'd0);
      chk("rst_state",     32'(dbg_state), 32'd0);
      chk_blk("rst_out_block", out_block, '0);
      reset = 1'b0;

      // Cb 4:2:0 ramp, free-flowing output
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ch     = 2'(CH_CB);
      in_mode   = 2'd2;
      in_block  = ramp;
      step();
      in_valid = 1'b0;
      chk("420_i0_valid", 32'(out_valid),       32'd1);
      chk("420_i0_state", 32'(dbg_state),       32'd1);
      chk("420_i0_idx",   32'(out_idx),         32'd0);
      chk("420_i0_last",  32'(out_last),        32'd0);
      chk("420_i0_ch",    32'(out_ch),          32'd1);
      chk("420_i0_merr",  32'(mode_err),        32'd0);
      chk("420_i0_p00",   32'(out_block[0][0]), 32'd0);
      chk("420_i0_p01",   32'(out_block[0][1]), 32'd0);
      chk("420_i0_p23",   32'(out_block[2][3]), 32'd9);
      chk("420_i0_p77",   32'(out_block[7][7]), 32'd27);
      step();
      chk("420_i1_idx",   32'(out_idx),         32'd1);
      chk("420_i1_last",  32'(out_last),        32'd0);
      chk("420_i1_p00",   32'(out_block[0][0]), 32'd4);
      chk("420_i1_p77",   32'(out_block[7][7]), 32'd31);
      step();
      chk("420_i2_idx",   32'(out_idx),         32'd2);
      chk("420_i2_last",  32'(out_last),        32'd0);
      chk("420_i2_p00",   32'(out_block[0][0]), 32'd32);
      chk("420_i2_p77",   32'(out_block[7][7]), 32'd59);
      step();
      chk("420_i3_idx",   32'(out_idx),         32'd3);
      chk("420_i3_last",  32'(out_last),        32'd1);
      chk("420_i3_rdy",   32'(in_ready),        32'd1);
      chk("420_i3_p00",   32'(out_block[0][0]), 32'd36);
      chk("420_i3_p77",   32'(out_block[7][7]), 32'd63);
      step();
      chk("420_done_valid", 32'(out_valid),     32'd0);
      chk("420_done_rdy",   32'(in_ready),      32'd1);

      // Cr 4:2:2 ramp
      in_valid = 1'b1;
      in_ch    = 2'(CH_CR);
      in_mode  = 2'd1;
      in_block = ramp;
      step();
      in_valid = 1'b0;
      chk("422_i0_ch",   32'(out_ch),          32'd2);
      chk("422_i0_last", 32'(out_last),        32'd0);
      chk("422_i0_p35",  32'(out_block[3][5]), 32'd26);
      chk("422_i0_p77",  32'(out_block[7][7]), 32'd59);
      step();
      chk("422_i1_idx",  32'(out_idx),         32'd1);
      chk("422_i1_last", 32'(out_last),        32'd1);
      chk("422_i1_p35",  32'(out_block[3][5]), 32'd30);
      chk("422_i1_p77",  32'(out_block[7][7]), 32'd63);
      step();
      chk("422_done_valid", 32'(out_valid),    32'd0);

      // Y with 4:2:0 mode then Cb 4:4:4, back-to-back
      in_valid = 1'b1;
      in_ch    = 2'(CH_Y);
      in_mode  = 2'd2;
      in_block = blk_a;
      step();
      in_ch    = 2'(CH_CB);
      in_mode  = 2'd0;
      in_block = blk_b;
      chk("b2b_y_valid", 32'(out_valid), 32'd1);
      chk("b2b_y_last",  32'(out_last),  32'd1);
      chk("b2b_y_rdy",   32'(in_ready),  32'd1);
      chk("b2b_y_ch",    32'(out_ch),    32'd0);
      chk_blk("b2b_y_blk", out_block, blk_a);
      step();
      in_valid = 1'b0;
      chk("b2b_cb_valid", 32'(out_valid), 32'd1);
      chk("b2b_cb_idx",   32'(out_idx),   32'd0);
      chk("b2b_cb_last",  32'(out_last),  32'd1);
      chk("b2b_cb_rdy",   32'(in_ready),  32'd1);
      chk("b2b_cb_ch",    32'(out_ch),    32'd1);
      chk_blk("b2b_cb_blk", out_block, blk_b);
      step();
      chk("b2b_done_valid", 32'(out_valid), 32'd0);

      // 4:2:0 with output stalls
      ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tl_exp    = '{8'd0, 8'd4, 8'd32, 8'd36};
      in_valid  = 1'b1;
      in_ch     = 2'(CH_CB);
      in_mode   = 2'd2;
      in_block  = ramp;
      step();
      in_valid = 1'b0;
      hs_cnt   = 0;
      stalled  = 1'b0;
      for (int k = 0; k < 24; k++) begin
         if (!out_valid) break;
         out_ready = (k < 8) ? ready_pat[k] : 1'b1;
         if (stalled) begin
            chk_blk("stall_blk", out_block, snap_blk);
            chk("stall_idx",  32'(out_idx),  32'(snap_idx));
            chk("stall_ch",   32'(out_ch),   32'(snap_ch));
            chk("stall_last", 32'(out_last), 32'(snap_last));
         end
         if (out_ready) begin
            chk("stall_hs_idx",  32'(out_idx),  32'(hs_cnt));
            chk("stall_hs_p00",  32'(out_block[0][0]), 32'(tl_exp[hs_cnt % 4]));
            chk("stall_hs_last", 32'(out_last), 32'(hs_cnt == 3));
            hs_cnt++;
         end
         stalled   = !out_ready;
         snap_blk  = out_block;
         snap_idx  = out_idx;
         snap_ch   = out_ch;
         snap_last = out_last;
         step();
      end
      chk("stall_hs_count", 32'(hs_cnt),    32'd4);
      chk("stall_done",     32'(out_valid), 32'd0);
      out_ready = 1'b1;

      // reset during emission
      in_valid = 1'b1;
      in_ch    = 2'(CH_CR);
      in_mode  = 2'd2;
      in_block = ramp;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("mid_rst_pre_idx", 32'(out_idx), 32'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_rdy",   32'(in_ready),  32'd1);
      chk("mid_rst_idx",   32'(out_idx),   32'd0);
      chk_blk("mid_rst_blk", out_block, '0);
      step();
      chk("mid_rst_idle", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_ch    = 2'(CH_CB);
      in_mode  = 2'd1;
      in_block = ramp;
      step();
      in_valid = 1'b0;
      chk("post_rst_idx",   32'(out_idx),         32'd0);
      chk("post_rst_valid", 32'(out_valid),       32'd1);
      chk("post_rst_p35",   32'(out_block[3][5]), 32'd26);
      step();
      chk("post_rst_idx1",  32'(out_idx),         32'd1);
      step();
      chk("post_rst_done",  32'(out_valid),       32'd0);

      // reserved mode on Cb
      in_valid = 1'b1;
      in_ch    = 2'(CH_CB);
      in_mode  = 2'd3;
      in_block = blk_b;
      step();
      in_valid = 1'b0;
      chk("rsvd_merr",  32'(mode_err),  32'd1);
      chk("rsvd_valid", 32'(out_valid), 32'd1);
      chk("rsvd_idx",   32'(out_idx),   32'd0);
      chk("rsvd_last",  32'(out_last),  32'd1);
      chk_blk("rsvd_blk", out_block, blk_b);
      step();
      chk("rsvd_merr_clr", 32'(mode_err),  32'd0);
      chk("rsvd_done",     32'(out_valid), 32'd0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
